// File: rtl/dmem_arbiter.sv
// Data memory arbiter: the pipeline MEM stage owns the port by default; the debug unit is granted
// one word access per request. Define DMEM_ARB_BOUNDS_CHECK_EN for range/alignment checking (o_err).
module dmem_arbiter #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_ADDR   = 32,
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pipe_read,
  input  logic               i_pipe_write,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  input  logic [1:0]         i_pipe_size,
  input  logic               i_pipe_unsigned,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  output logic               o_pipe_stall,
  input  logic               i_dbg_req,
  input  logic               i_dbg_write,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic               o_dbg_ack,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic [1:0]         o_mem_size,
  output logic               o_mem_unsigned,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic               o_err
);

  localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef enum logic [1:0] {StPipe, StDbgAcc, StDbgResp} state_e;

  state_e             state_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic               rearm_block_q;
  logic               pipe_rd_q;
  logic               pipe_rd_bad_q;
  logic               dbg_wr_q;
  logic               dbg_bad_q;
  logic               err_q;
  logic [NB_DATA-1:0] pipe_hold_q;
  logic [NB_DATA-1:0] dbg_rdata_q;

  logic               pipe_busy;
  logic               pipe_rd;
  logic               acc_rd;
  logic               acc_wr;
  logic               acc_bad;
  logic [NB_ADDR-1:0] acc_addr;
  logic [1:0]         acc_size;
  logic [NB_DATA-1:0] pipe_rdata;
  logic [NB_DATA-1:0] dbg_rdata;

  assign pipe_busy = i_pipe_read | i_pipe_write;
  assign pipe_rd   = i_pipe_read & ~i_pipe_write;

  // Access source selected by the state register, so a grant never glitches the current cycle.
  always_comb begin
    acc_rd         = 1'b0;
    acc_wr         = 1'b0;
    acc_addr       = i_pipe_addr;
    acc_size       = i_pipe_size;
    o_mem_wdata    = i_pipe_wdata;
    o_mem_unsigned = i_pipe_unsigned;
    case (state_q)
      StPipe: begin
        acc_rd = pipe_rd;
        acc_wr = i_pipe_write;
      end
      StDbgAcc: begin
        acc_rd         = ~i_dbg_write;
        acc_wr         = i_dbg_write;
        acc_addr       = i_dbg_addr;
        acc_size       = 2'b11;
        o_mem_wdata    = i_dbg_wdata;
        o_mem_unsigned = 1'b0;
      end
      default: begin
        acc_addr       = i_dbg_addr;
        acc_size       = 2'b11;
        o_mem_wdata    = i_dbg_wdata;
        o_mem_unsigned = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_bad = 1'b0;
    if (ChkEn) begin
      if (acc_addr >= NB_ADDR'(MEM_BYTES)) acc_bad = 1'b1;
      if ((acc_size == 2'b01) && acc_addr[0]) acc_bad = 1'b1;
      if (acc_size[1] && (acc_addr[1:0] != 2'b00)) acc_bad = 1'b1;
    end
  end

  // Reset gates the strobes so an access in flight when reset hits never reaches memory.
  assign o_mem_read  = acc_rd & ~acc_bad & ~i_reset;
  assign o_mem_write = acc_wr & ~acc_bad & ~i_reset;
  assign o_mem_addr  = acc_addr;
  assign o_mem_size  = acc_size;

  assign pipe_rdata   = pipe_rd_q ? (pipe_rd_bad_q ? '0 : i_mem_rdata) : pipe_hold_q;
  assign dbg_rdata    = ((state_q == StDbgResp) && !dbg_wr_q) ?
                        (dbg_bad_q ? '0 : i_mem_rdata) : dbg_rdata_q;
  assign o_pipe_rdata = pipe_rdata;
  assign o_dbg_rdata  = dbg_rdata;
  assign o_pipe_stall = (state_q != StPipe);
  assign o_dbg_ack    = (state_q == StDbgResp) & ~i_reset;
  assign o_err        = ChkEn ? err_q : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StPipe;
      wait_cnt_q    <= '0;
      rearm_block_q <= 1'b0;
      pipe_rd_q     <= 1'b0;
      pipe_rd_bad_q <= 1'b0;
      dbg_wr_q      <= 1'b0;
      dbg_bad_q     <= 1'b0;
      err_q         <= 1'b0;
      pipe_hold_q   <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      pipe_rd_q     <= (state_q == StPipe) & pipe_rd;
      pipe_rd_bad_q <= acc_bad;
      err_q         <= err_q | (acc_bad & (acc_rd | acc_wr));
      if (pipe_rd_q) pipe_hold_q <= pipe_rdata;
      case (state_q)
        StPipe: begin
          rearm_block_q <= 1'b0;
          if (!i_dbg_req || rearm_block_q) begin
            wait_cnt_q <= '0;
          end else if (!pipe_busy || (wait_cnt_q == WaitMax)) begin
            state_q    <= StDbgAcc;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDbgAcc: begin
          state_q   <= StDbgResp;
          dbg_wr_q  <= i_dbg_write;
          dbg_bad_q <= acc_bad;
        end
        default: begin
          state_q       <= StPipe;
          rearm_block_q <= 1'b1;
          if (!dbg_wr_q) dbg_rdata_q <= dbg_rdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed pipe/debug traffic checked every cycle against a model built
// on grant timestamps and a reference word memory, plus hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int MaxWait = 8;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_read, i_pipe_write, i_pipe_unsigned;
  logic [31:0] i_pipe_addr, i_pipe_wdata;
  logic [1:0]  i_pipe_size;
  logic [31:0] o_pipe_rdata;
  logic        o_pipe_stall;
  logic        i_dbg_req, i_dbg_write;
  logic [31:0] i_dbg_addr, i_dbg_wdata;
  logic        o_dbg_ack;
  logic [31:0] o_dbg_rdata;
  logic        o_mem_read, o_mem_write, o_mem_unsigned;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [1:0]  o_mem_size;
  logic [31:0] i_mem_rdata;
  logic        o_err;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NB_DATA(32), .NB_ADDR(32), .MAX_WAIT(MaxWait), .MEM_BYTES(1024)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_pipe_read(i_pipe_read), .i_pipe_write(i_pipe_write), .i_pipe_addr(i_pipe_addr),
    .i_pipe_wdata(i_pipe_wdata), .i_pipe_size(i_pipe_size), .i_pipe_unsigned(i_pipe_unsigned),
    .o_pipe_rdata(o_pipe_rdata), .o_pipe_stall(o_pipe_stall),
    .i_dbg_req(i_dbg_req), .i_dbg_write(i_dbg_write), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size), .o_mem_unsigned(o_mem_unsigned),
    .i_mem_rdata(i_mem_rdata), .o_err(o_err)
  );

  // Word-wide data memory with one-cycle read latency.
  logic [31:0] mem [256];
  logic [31:0] mem_rdata_q;
  assign i_mem_rdata = mem_rdata_q;
  always @(posedge clk) begin
    if (o_mem_write) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    if (o_mem_read) mem_rdata_q <= mem[o_mem_addr[9:2]];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pipe owns every cycle except grant+1 (debug access) and grant+2 (ack);
  // the cycle at grant+3 ignores a still-high request.
  int          g = -100;
  int          waited = 0;
  logic        model_ok = 1'b0;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_prd = '0;
  logic [31:0] exp_drd = '0;

  initial forever begin
    @(posedge clk);
    if (i_reset) begin
      g = -100; waited = 0; exp_prd = '0; exp_drd = '0; model_ok = 1'b1;
    end else if (cyc == g + 1) begin
      if (i_dbg_write) ref_mem[i_dbg_addr[9:2]] = i_dbg_wdata;
      else exp_drd = ref_mem[i_dbg_addr[9:2]];
    end else if (cyc != g + 2) begin
      if (i_pipe_write) ref_mem[i_pipe_addr[9:2]] = i_pipe_wdata;
      else if (i_pipe_read) exp_prd = ref_mem[i_pipe_addr[9:2]];
      if (i_dbg_req && cyc != g + 3) begin
        if (!(i_pipe_read || i_pipe_write) || waited == MaxWait) begin
          g = cyc; waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
    cyc++;
  end

  initial begin
    logic acc, resp, exp_wr, exp_rd;
    forever begin
      @(negedge clk);
      if (model_ok && !i_reset) begin
        acc  = (cyc == g + 1);
        resp = (cyc == g + 2);
        exp_wr = acc ? i_dbg_write : (resp ? 1'b0 : i_pipe_write);
        exp_rd = acc ? ~i_dbg_write : (resp ? 1'b0 : (i_pipe_read & ~i_pipe_write));
        chk("stall", 32'(o_pipe_stall), 32'(acc | resp));
        chk("ack", 32'(o_dbg_ack), 32'(resp));
        chk("pipe_rdata", o_pipe_rdata, exp_prd);
        chk("dbg_rdata", o_dbg_rdata, exp_drd);
        chk("mem_write", 32'(o_mem_write), 32'(exp_wr));
        chk("mem_read", 32'(o_mem_read), 32'(exp_rd));
        if (exp_wr || exp_rd) chk("mem_addr", o_mem_addr, acc ? i_dbg_addr : i_pipe_addr);
        if (exp_wr) chk("mem_wdata", o_mem_wdata, acc ? i_dbg_wdata : i_pipe_wdata);
        if (acc) chk("mem_size", 32'(o_mem_size), 32'(2'b11));
        if (o_pipe_stall) stall_cnt++;
        if (o_dbg_ack) ack_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    logic st;
    int   n;
    i_pipe_read = rd; i_pipe_write = wr; i_pipe_addr = addr; i_pipe_wdata = data;
    n = 0;
    do begin
      st = o_pipe_stall;
      tick();
      n++;
    end while (st && n < 10);
    i_pipe_read = 1'b0; i_pipe_write = 1'b0;
  endtask

  task automatic dbg_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output int ack_cyc, output logic [31:0] rd);
    i_dbg_req = 1'b1; i_dbg_write = wr; i_dbg_addr = addr; i_dbg_wdata = data;
    ack_cyc = -1; rd = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (o_dbg_ack) begin
        ack_cyc = cyc; rd = o_dbg_rdata;
        break;
      end
    end
    i_dbg_req = 1'b0;
    chk("dbg_ack_seen", 32'(ack_cyc >= 0), 32'd1);
  endtask

  initial begin
    int          ac, req_cyc, s0, a0, first, second, nack;
    logic [31:0] rd;
    i_reset = 1'b1;
    i_pipe_read = 1'b0; i_pipe_write = 1'b0; i_pipe_addr = '0; i_pipe_wdata = '0;
    i_pipe_size = 2'b11; i_pipe_unsigned = 1'b0;
    i_dbg_req = 1'b0; i_dbg_write = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    repeat (2) tick();
    i_reset = 1'b0;
    #1;
    chk("rst_stall", 32'(o_pipe_stall), 32'd0);
    chk("rst_ack", 32'(o_dbg_ack), 32'd0);
    chk("rst_pipe_rdata", o_pipe_rdata, 32'd0);
    chk("rst_dbg_rdata", o_dbg_rdata, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);

    // Pipe-only traffic
    s0 = stall_cnt;
    for (int i = 0; i < 20; i++) pipe_op(1'b0, 1'b1, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 20; i++) begin
      pipe_op(1'b1, 1'b0, 32'(i * 4), '0);
      chk("pipe_readback", o_pipe_rdata, 32'(i + 1));
    end
    pipe_op(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF);
    chk("pipe_only_stalls", 32'(stall_cnt - s0), 32'd0);
    tick();

    // Debug read while the pipe is idle
    s0 = stall_cnt; a0 = ack_cnt; req_cyc = cyc;
    dbg_op(1'b0, 32'd8, '0, ac, rd);
    chk("dbg_rd_data", rd, 32'hDEAD_BEEF);
    chk("dbg_rd_latency", 32'(ac - req_cyc), 32'd2);
    repeat (2) tick();
    chk("dbg_rd_stalls", 32'(stall_cnt - s0), 32'd2);
    chk("dbg_rd_acks", 32'(ack_cnt - a0), 32'd1);

    // Starvation bound: loads every cycle while debug writes 0x55 to 0x40
    req_cyc = cyc;
    fork
      begin
        for (int i = 0; i < 20; i++) pipe_op(1'b1, 1'b0, 32'(i * 4), '0);
      end
      begin
        int          sac;
        logic [31:0] srd;
        dbg_op(1'b1, 32'h40, 32'h55, sac, srd);
        chk("starve_latency", 32'(sac - req_cyc), 32'(MaxWait + 2));
      end
    join
    chk("starve_mem", mem[16], 32'h55);
    repeat (2) tick();

    // Pipe write and debug request in the same cycle: the pipe write goes first
    i_pipe_write = 1'b1; i_pipe_addr = 32'h50; i_pipe_wdata = 32'hA5A5_0001;
    i_dbg_req = 1'b1; i_dbg_write = 1'b0; i_dbg_addr = 32'h50;
    req_cyc = cyc;
    #1;
    chk("prio_mem_write", 32'(o_mem_write), 32'd1);
    chk("prio_mem_addr", o_mem_addr, 32'h50);
    tick();
    i_pipe_write = 1'b0;
    dbg_op(1'b0, 32'h50, '0, ac, rd);
    chk("prio_dbg_data", rd, 32'hA5A5_0001);
    chk("prio_latency", 32'(ac - req_cyc), 32'd3);
    repeat (2) tick();

    // Request held through ack: second service waits out the rearm cycle
    i_dbg_req = 1'b1; i_dbg_write = 1'b0; i_dbg_addr = 32'd8;
    req_cyc = cyc; first = -1; second = -1; nack = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_dbg_ack) begin
        nack++;
        if (first < 0) first = cyc;
        else begin
          second = cyc;
          i_dbg_req = 1'b0;
        end
      end
    end
    i_dbg_req = 1'b0;
    chk("rearm_first", 32'(first - req_cyc), 32'd2);
    chk("rearm_gap", 32'(second - first), 32'd4);
    chk("rearm_acks", 32'(nack), 32'd2);
    tick();

    // Reset while in the debug access cycle of a write
    i_dbg_req = 1'b1; i_dbg_write = 1'b1; i_dbg_addr = 32'd0; i_dbg_wdata = 32'hFF;
    tick();
    chk("rst_acc_stall", 32'(o_pipe_stall), 32'd1);
    i_reset = 1'b1; i_dbg_req = 1'b0;
    tick();
    i_reset = 1'b0;
    chk("rst_after_stall", 32'(o_pipe_stall), 32'd0);
    chk("rst_after_ack", 32'(o_dbg_ack), 32'd0);
    a0 = ack_cnt;
    repeat (4) tick();
    chk("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("rst_mem0", mem[0], 32'd1);

    for (int w = 0; w <= 20; w++) chk("mem_word", mem[w], ref_mem[w]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
